// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access sequencer: FSM states, access size codes,
// wait-state counter width, and the alignment rule used when a request is accepted.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RMW    = 3'd2,
    ST_DONE   = 3'd3,
    ST_REJECT = 3'd4
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Wide enough for WAIT_CYCLES in 0..15
  localparam int WCNT_W = 4;

  // True when the byte offset is not a multiple of the access size; the unused code 11 never aligns
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      SZ_WORD: return ofs != 2'b00;
      SZ_HALF: return ofs[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/subword_lane_unit.sv
// Little-endian lane handling for sub-word accesses: extract/extend a lane for loads,
// and merge store data into the word read back from RAM.
// Purely combinational, zero latency; no flow control.
import mem_access_pkg::*;

module subword_lane_unit (
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed lane, extend it for loads, and overlay store data on the old word
  always_comb begin
    byte_v   = rdata[{lane, 3'b000} +: 8];
    half_v   = rdata[{lane[1], 4'b0000} +: 16];
    load_val = rdata;
    merged   = wdata;
    case (size)
      SZ_BYTE: begin
        load_val = sign_ext ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
        merged   = rdata;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = sign_ext ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        merged   = rdata;
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_val = rdata;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle fetch/load/store sequencer in front of the unified RAM; optional sub-word support via SUBWORD_ACCESS_EN.
// Ack WAIT_CYCLES+2 cycles after acceptance (WAIT_CYCLES+3 for read-modify-write stores), 1 cycle for rejects.
// One request at a time: req is sampled only in IDLE and ignored while busy; the requester re-issues after ack.
import mem_access_pkg::*;

module mem_access_ctrl #(
  parameter int RAM_SIZE      = 256,
  parameter int RAM_INST_SIZE = 32,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic        req_inst,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] ir_out,
  output logic [31:0] mdr_out,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0]       ADDR_LIMIT = 32'(4 * RAM_SIZE);
  localparam logic [29:0]       INST_LIMIT = 30'(RAM_INST_SIZE);
  localparam logic [WCNT_W-1:0] WCNT_INIT  = WCNT_W'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              we_q, we_d;
  logic              inst_q, inst_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       rd_val;
  logic              req_sub;
  logic              req_misalign;
  logic              req_bad;

`ifdef SUBWORD_ACCESS_EN
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        acc_sub;
  logic [31:0] merged;

  // wdata_q doubles as the merge buffer: raw store data during the read phase, merged word for the write
  subword_lane_unit u_lane (
    .rdata    (mem_rdata),
    .wdata    (wdata_q),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (signed_q),
    .load_val (rd_val),
    .merged   (merged)
  );

  assign req_sub      = req_we && (req_size != SZ_WORD);
  assign acc_sub      = we_q && (size_q != SZ_WORD);
  assign req_misalign = misaligned(req_size, req_addr[1:0]);
`else
  // Size and sign controls have no meaning when every access is a full word
  logic unused_subword;
  assign unused_subword = ^{req_size, req_signed};
  assign rd_val         = mem_rdata;
  assign req_sub        = 1'b0;
  assign req_misalign   = misaligned(SZ_WORD, req_addr[1:0]);
`endif

  assign req_bad = req_misalign || (req_addr >= ADDR_LIMIT) ||
                   (req_we && (req_addr[31:2] < INST_LIMIT));

  // Next-state and next-output logic; strobes default low so they only pulse where set
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef SUBWORD_ACCESS_EN
    size_d   = size_q;
    signed_d = signed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = req_we;
          inst_d  = req_inst;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wcnt_d  = WCNT_INIT;
`ifdef SUBWORD_ACCESS_EN
          size_d   = req_size;
          signed_d = req_signed;
`endif
          if (req_bad) begin
            state_d = ST_REJECT;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            rd_d    = !req_we || req_sub;
            // A word store with no wait states writes in its first ACCESS cycle
            wr_d    = req_we && !req_sub && (WAIT_CYCLES == 0);
          end
        end
      end
      ST_ACCESS: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
          rd_d   = rd_q;
          // Raise the word-store strobe for the cycle in which the count reaches zero
`ifdef SUBWORD_ACCESS_EN
          wr_d   = we_q && !acc_sub && (wcnt_q == WCNT_W'(1));
`else
          wr_d   = we_q && (wcnt_q == WCNT_W'(1));
`endif
        end else if (!we_q) begin
          if (inst_q) ir_d = rd_val;
          else        mdr_d = rd_val;
          state_d = ST_DONE;
          ack_d   = 1'b1;
`ifdef SUBWORD_ACCESS_EN
        end else if (acc_sub) begin
          wdata_d = merged;
          wr_d    = 1'b1;
          state_d = ST_RMW;
`endif
        end else begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
        end
      end
`ifdef SUBWORD_ACCESS_EN
      ST_RMW: begin
        state_d = ST_DONE;
        ack_d   = 1'b1;
      end
`endif
      ST_DONE, ST_REJECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // State and registered outputs; synchronous reset wins in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      inst_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ir_q    <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef SUBWORD_ACCESS_EN
      size_q   <= SZ_WORD;
      signed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef SUBWORD_ACCESS_EN
      size_q   <= size_d;
      signed_q <= signed_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign ir_out    = ir_q;
  assign mdr_out   = mdr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;

endmodule
